// File: rtl/mul_bus_arbiter.sv
// Round-robin master for the shared multiplier slave.
// Grants one requester, writes its operands and a start flag to the slave,
// waits for ready, reads the product back and pulses done for that requester.
// Optional build macro MUL_TIMEOUT_EN adds a WAIT watchdog that aborts the
// job with err=1 and result=0 after TIMEOUT cycles without ready.
module mul_bus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned RES_ADR = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [31:0]       result,
  output logic              err,
  output logic              busy,
  output logic              signal,
  output logic [4:0]        w_adr,
  output logic [31:0]       w_data,
  output logic [4:0]        r_adr,
  input  logic [31:0]       r_data,
  input  logic              ready
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StWrA, StWrB, StWrGo, StWait, StClr, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic              busy_q, busy_d;
  logic              signal_q, signal_d;
  logic [4:0]        w_adr_q, w_adr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              win_found;
  logic [IdxW-1:0]   win_idx;

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign signal = signal_q;
  assign w_adr  = w_adr_q;
  assign w_data = w_data_q;
  assign r_adr  = 5'(RES_ADR);

  // Round-robin search: first set req bit strictly after rr_q, wrapping.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = rr_q;
    for (int k = 1; k <= int'(NREQ); k++) begin
      j = int'(rr_q) + k;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(j);
      end
    end
  end

  // Next state plus the registered value of every output for the next cycle.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    signal_d = 1'b0;
    w_adr_d  = w_adr_q;
    w_data_d = w_data_q;
`ifdef MUL_TIMEOUT_EN
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d          = win_idx;
          a_d            = req_a[16*win_idx +: 16];
          b_d            = req_b[16*win_idx +: 16];
          gnt_d[win_idx] = 1'b1;
          state_d        = StWrA;
`ifdef MUL_TIMEOUT_EN
          abort_d        = 1'b0;
`endif
        end
      end
      StWrA: begin
        signal_d = 1'b1;
        w_adr_d  = 5'd1;
        w_data_d = {16'h0, a_q};
        state_d  = StWrB;
      end
      StWrB: begin
        signal_d = 1'b1;
        w_adr_d  = 5'd2;
        w_data_d = {16'h0, b_q};
        state_d  = StWrGo;
      end
      StWrGo: begin
        // ready in this cycle belongs to a stale job, so it is not looked at.
        signal_d = 1'b1;
        w_adr_d  = 5'd0;
        w_data_d = 32'd1;
        state_d  = StWait;
`ifdef MUL_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      StWait: begin
        w_adr_d  = 5'd0;
        w_data_d = 32'd1;
        if (ready) begin
          result_d = r_data;
          state_d  = StClr;
        end
`ifdef MUL_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          result_d = 32'd0;
          abort_d  = 1'b1;
          state_d  = StClr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StClr: begin
        signal_d = 1'b1;
        w_adr_d  = 5'd0;
        w_data_d = 32'd0;
        state_d  = StDone;
      end
      StDone: begin
        done_d[idx_q] = 1'b1;
        rr_d          = idx_q;
        state_d       = StIdle;
`ifdef MUL_TIMEOUT_EN
        err_d         = abort_q;
`endif
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset abandons any job without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_q     <= IdxW'(NREQ - 1);
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      signal_q <= 1'b0;
      w_adr_q  <= '0;
      w_data_q <= '0;
`ifdef MUL_TIMEOUT_EN
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      signal_q <= signal_d;
      w_adr_q  <= w_adr_d;
      w_data_q <= w_data_d;
`ifdef MUL_TIMEOUT_EN
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_bus_arbiter.sv
// Directed bench for mul_bus_arbiter with a small multiplier-slave model.
module tb_mul_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  gnt, done;
  logic [31:0] result;
  logic        err, busy, signal;
  logic [4:0]  w_adr, r_adr;
  logic [31:0] w_data, r_data;
  logic        ready;

  int checks = 0;
  int failures = 0;

  // Slave model: ready rises slv_delay cycles after it sees the start write.
  int          slv_delay = 2;
  int          s_cnt;
  logic        s_run;
  logic [15:0] s_a, s_b;
  logic        force_rdy = 1'b0;

  always #5 clk = ~clk;

  mul_bus_arbiter #(.NREQ(4), .RES_ADR(3), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .signal(signal), .w_adr(w_adr), .w_data(w_data), .r_adr(r_adr),
    .r_data(r_data), .ready(ready)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_run <= 1'b0;
      s_cnt <= 0;
      s_a   <= '0;
      s_b   <= '0;
    end else if (signal) begin
      if (w_adr == 5'd1) s_a <= w_data[15:0];
      else if (w_adr == 5'd2) s_b <= w_data[15:0];
      else if (w_adr == 5'd0) begin
        if (w_data == 32'd1) begin
          s_run <= 1'b1;
          s_cnt <= slv_delay;
        end else begin
          s_run <= 1'b0;
        end
      end
    end else if (s_run && s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
    end
  end

  assign ready  = (s_run && s_cnt == 0) || force_rdy;
  assign r_data = {16'h0, s_a} * {16'h0, s_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks the bus sequence, latency and done pulse.
  task automatic do_job(input int exp_idx, input logic [15:0] ea, input logic [15:0] eb,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat,
                        input logic [3:0] req_after, input bit glitch);
    bit          got;
    int          lat;
    logic        p_sig;
    logic [4:0]  p_adr;
    logic [31:0] p_dat;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (gnt != 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("gnt_onehot", 32'(gnt), 32'(4'b0001 << exp_idx));
    chk("busy_at_gnt", 32'(busy), 32'd1);
    req = req_after;
    @(negedge clk);
    chk("gnt_pulse", 32'(gnt), 32'd0);
    chk("wr_a", {signal, 1'b0, w_adr, w_data[24:0]}, {1'b1, 1'b0, 5'd1, 9'd0, ea});
    @(negedge clk);
    chk("wr_b", {signal, 1'b0, w_adr, w_data[24:0]}, {1'b1, 1'b0, 5'd2, 9'd0, eb});
    if (glitch) force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    chk("wr_go", {signal, 1'b0, w_adr, w_data[24:0]}, {1'b1, 1'b0, 5'd0, 25'd1});
    @(negedge clk);
    chk("wait_hold", {signal, 1'b0, w_adr, w_data[24:0]}, {1'b0, 1'b0, 5'd0, 25'd1});
    lat = 4;
    p_sig = signal;
    p_adr = w_adr;
    p_dat = w_data;
    while (done == 0 && lat < 3000) begin
      p_sig = signal;
      p_adr = w_adr;
      p_dat = w_data;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("clr_write", {p_sig, 1'b0, p_adr, p_dat[24:0]}, {1'b1, 1'b0, 5'd0, 25'd0});
    chk("done_onehot", 32'(done), 32'(4'b0001 << exp_idx));
    chk("result", result, exp_res);
    chk("err", 32'(err), 32'(exp_err));
    chk("busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("err_pulse", 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // Reset values
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {29'd0, err, busy, signal}, 32'd0);
    chk("rst_w_adr", 32'(w_adr), 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("r_adr", 32'(r_adr), 32'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(busy), 32'd0);

    // Single job: 300*7, ready in 4th WAIT cycle -> N=4, latency 9
    slv_delay = 2;
    req_a[0 +: 16] = 16'd300;
    req_b[0 +: 16] = 16'd7;
    req = 4'b0001;
    do_job(0, 16'd300, 16'd7, 32'd2100, 1'b0, 9, 4'b0000, 1'b0);

    // Round-robin skip: last served 0, so 2 goes before 0
    req_a[0 +: 16]  = 16'd12345;
    req_b[0 +: 16]  = 16'd2;
    req_a[32 +: 16] = 16'd1000;
    req_b[32 +: 16] = 16'd1000;
    slv_delay = 1;
    req = 4'b0101;
    do_job(2, 16'd1000, 16'd1000, 32'h000F4240, 1'b0, 8, 4'b0001, 1'b0);
    slv_delay = 3;
    do_job(0, 16'd12345, 16'd2, 32'd24690, 1'b0, 10, 4'b0000, 1'b0);

    // Full range, fastest slave, plus a stray ready during WR_GO
    req_a[48 +: 16] = 16'hFFFF;
    req_b[48 +: 16] = 16'hFFFF;
    slv_delay = 0;
    req = 4'b1000;
    do_job(3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 7, 4'b0000, 1'b1);

    // Fairness with all requests held: order 0,1,2,3,0
    req_a = {16'd13, 16'd12, 16'd11, 16'd10};
    req_b = {16'd23, 16'd22, 16'd21, 16'd20};
    slv_delay = 2;
    req = 4'b1111;
    do_job(0, 16'd10, 16'd20, 32'd200, 1'b0, 9, 4'b1111, 1'b0);
    do_job(1, 16'd11, 16'd21, 32'd231, 1'b0, 9, 4'b1111, 1'b0);
    do_job(2, 16'd12, 16'd22, 32'd264, 1'b0, 9, 4'b1111, 1'b0);
    do_job(3, 16'd13, 16'd23, 32'd299, 1'b0, 9, 4'b1111, 1'b0);
    do_job(0, 16'd10, 16'd20, 32'd200, 1'b0, 9, 4'b0000, 1'b0);

    // Reset during WAIT
    slv_delay = 50;
    req_a[16 +: 16] = 16'd5;
    req_b[16 +: 16] = 16'd5;
    req = 4'b0010;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gnt != 0) begin
        got = 1'b1;
        break;
      end
    end
    chk("rstjob_gnt", 32'(gnt), 32'd2);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("rstjob_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {27'd0, gnt, err}, 32'd0);
    chk("midrst_bus", {26'd0, busy, signal, 4'd0}, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_w", {w_adr, w_data[26:0]}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", {27'd0, done, busy}, 32'd0);
    end
    slv_delay = 4;
    req_a[32 +: 16] = 16'd40000;
    req_b[32 +: 16] = 16'd3;
    req = 4'b0100;
    do_job(2, 16'd40000, 16'd3, 32'h0001D4C0, 1'b0, 11, 4'b0000, 1'b0);

`ifdef MUL_TIMEOUT_EN
    // Slave never answers: 10 WAIT cycles then abort
    slv_delay = 100000;
    req_a[0 +: 16] = 16'd9;
    req_b[0 +: 16] = 16'd9;
    req = 4'b0001;
    do_job(0, 16'd9, 16'd9, 32'd0, 1'b1, 15, 4'b0000, 1'b0);
    slv_delay = 2;
    req_a[16 +: 16] = 16'd6;
    req_b[16 +: 16] = 16'd7;
    req = 4'b0010;
    do_job(1, 16'd6, 16'd7, 32'd42, 1'b0, 9, 4'b0000, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
